aes128_encrypt_core: RTL and testbench
======================================

# aes128_encrypt_core

Iterative AES-128 encryption datapath computing one round per clock. It sits directly downstream of the key-schedule block: it drives that block's round-select input and consumes the combinational 128-bit round key it returns. It encrypts one 128-bit block per request and presents the ciphertext to the CTR keystream logic with a single-cycle `done` pulse.

## Interface

- No parameters. Fixed at AES-128: 10 rounds.
- `clk` input, 1 bit. Clock; all state updates on the rising edge.
- `rst_n` input, 1 bit. Reset, asynchronous, active-low.
- `start` input, 1 bit. Encrypt request, sampled on the clock edge.
- `block_in` input, 128 bits. Plaintext. Bits [127:120] are state byte 0; bytes are column-major, so bytes 0–3 form column 0.
- `key_ready` input, 1 bit. Level signal from the key schedule: the round keys are valid.
- `round_key` input, 128 bits. Round key for `round_sel`. Combinational, valid in the same cycle.
- `round_sel` output, 4 bits. Index of the round key requested (0–10).
- `busy` output, 1 bit. High while a block is in flight.
- `done` output, 1 bit. One-cycle pulse: `block_out` was updated.
- `block_out` output, 128 bits. Ciphertext. Holds its value until the next `done`.

## Operation

- State machine has two states: IDLE and RUN. A 4-bit round counter `rnd` and a 128-bit state register `st` hold the working data.
- IDLE:
  - `round_sel` = 0.
  - If `start && key_ready`: `st <= block_in ^ round_key`, `rnd <= 1`, go to RUN.
  - Otherwise `start` is ignored. Requests are not queued.
- RUN:
  - `round_sel` = `rnd`.
  - If `rnd` is 1–9: `st <= AddRoundKey(MixColumns(ShiftRows(SubBytes(st))), round_key)`, `rnd <= rnd+1`.
  - If `rnd` = 10: final round without MixColumns. `block_out <= AddRoundKey(ShiftRows(SubBytes(st)), round_key)`, `done <= 1`, return to IDLE.
- `start` while in RUN is ignored and does not disturb the block in flight.
- `key_ready` deasserted in RUN (for example, the key schedule was restarted): abort.
  - Return to IDLE, no `done`.
  - `block_out` keeps its previous value.
  - `rnd` and `st` are don't-care after abort.
- SubBytes uses 16 forward S-box instances, the same S-box used by the key schedule.
- MixColumns works over GF(2^8) with xtime reduction polynomial 0x11B.
- All XOR and GF arithmetic is 8-bit per byte, with no carries between bytes.
- `busy` = (state == RUN). It is a registered state decode.

## Timing

- Reset values:
  - state = IDLE, `rnd` = 0, `st` = 0.
  - `busy` = 0, `done` = 0, `block_out` = 0, `round_sel` = 0.
- Latency, taking the cycle in which `start` is sampled high as cycle 0:
  - `busy` is high in cycles 1–10.
  - `done` and the new `block_out` appear in cycle 11.
- Throughput: a new `start` can be accepted in cycle 11 (IDLE, `done` high). That gives one block per 11 cycles back-to-back.
- `done` is high for exactly one cycle per completed block and is never asserted after an abort.
- `round_sel` is a registered-state decode. `round_key` is therefore expected to settle combinationally in the same cycle. This is a single-cycle path through the key schedule's output mux.
- `block_in` is needed only in the `start` cycle; it may change afterwards.
- Reset asserted mid-operation: all outputs return to their reset values immediately (asynchronously), and no `done` is issued.

## Test plan

- FIPS-197 App. B: key `2b7e151628aed2a6abf7158809cf4f3c`, `block_in` = `3243f6a8885a308d313198a2e0370734`, `start` for 1 cycle -> `done` in cycle 11, `block_out` = `3925841d02dc09fbdc118597196a0b32`, `busy` high in cycles 1–10.
- FIPS-197 App. C.1: key `000102030405060708090a0b0c0d0e0f`, `block_in` = `00112233445566778899aabbccddeeff` -> `block_out` = `69c4e0d86a7b0430d8cdb78070b4c55a`. Then issue a second `start` in the `done` cycle -> second `done` 11 cycles later.
- `start` with `key_ready` = 0 -> stays IDLE; `busy` and `done` remain 0 for 20 cycles; `block_out` unchanged.
- `start` pulsed again in cycle 5 while busy -> ignored; a single `done` in cycle 11 with the correct App. B ciphertext.
- `key_ready` dropped in cycle 6 -> `busy` low by cycle 7, no `done`, `block_out` retains the prior ciphertext.
- `rst_n` asserted in cycle 4 -> `busy`, `done` and `block_out` are 0 immediately. After release, a fresh App. C.1 run passes.

Source files
------------

// File: rtl/aes128_encrypt_core_if.sv
// Request, key-schedule and result signals of the iterative AES-128 encrypt core.
// The master side is the CTR keystream logic together with the key schedule.
interface aes128_encrypt_core_if;
    logic         start;
    logic [127:0] block_in;
    logic         key_ready;
    logic [127:0] round_key;
    logic [3:0]   round_sel;
    logic         busy;
    logic         done;
    logic [127:0] block_out;
    logic         state_dbg;

    modport master (
        output start, block_in, key_ready, round_key,
        input  round_sel, busy, done, block_out, state_dbg
    );

    modport slave (
        input  start, block_in, key_ready, round_key,
        output round_sel, busy, done, block_out, state_dbg
    );
endinterface

// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption, one round per clock, 11-cycle latency from start to done.
// Handshake: a request is taken when start && key_ready are high at an edge in IDLE; done pulses one cycle, block_out holds until the next done.
module aes128_encrypt_core (
    input logic                  clk,
    input logic                  rst_n,
    aes128_encrypt_core_if.slave bus
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t       state;
    logic [3:0]   rnd;
    logic [127:0] st;
    logic         busy_q;
    logic         done_q;
    logic [127:0] block_out_q;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3);
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Byte-indexed views: element 0 is bits [127:120], bytes run column-major.
    logic [0:15][7:0] st_b;
    logic [0:15][7:0] sb;
    logic [0:15][7:0] sr;
    logic [0:15][7:0] mc;
    logic [127:0]     round_next;
    logic [127:0]     final_next;

    always_comb begin
        st_b = st;
        sb   = '0;
        sr   = '0;
        mc   = '0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = sbox(st_b[i]);
        end
        // Row r rotates left by r columns.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[4*c +: 4] = mix_col(sr[4*c], sr[4*c + 1], sr[4*c + 2], sr[4*c + 3]);
        end
        round_next = mc ^ bus.round_key;
        final_next = sr ^ bus.round_key;
    end

    // rnd is forced to 0 whenever the FSM is idle so it can drive round_sel directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rnd         <= 4'd0;
            st          <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            block_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && bus.key_ready) begin
                        st     <= bus.block_in ^ bus.round_key;
                        rnd    <= 4'd1;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.key_ready) begin
                        rnd    <= 4'd0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (rnd == 4'd10) begin
                        block_out_q <= final_next;
                        done_q      <= 1'b1;
                        rnd         <= 4'd0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        st  <= round_next;
                        rnd <= rnd + 4'd1;
                    end
                end
                default: begin
                    rnd    <= 4'd0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.round_sel = rnd;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.block_out = block_out_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Bench for aes128_encrypt_core: FIPS-197 vectors, back-to-back, ignored starts, abort and mid-run reset.
// The bench plays the key schedule, expanding the key itself and answering round_sel combinationally.
module tb_aes128_encrypt_core;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    aes128_encrypt_core_if bus ();

    aes128_encrypt_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [127:0] rk_tab [16];
    logic [127:0] exp_q [$];
    logic [127:0] exp_v;
    int           checks = 0;
    int           errors = 0;
    int           cyc;
    logic [31:0]  busy_hist;
    int           done_cnt;
    int           done_cyc;
    logic [127:0] done_val;

    always_comb bus.round_key = rk_tab[bus.round_sel];

    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        return SBOX[(255 - int'(x)) * 8 +: 8];
    endfunction

    task automatic set_key(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
                t[31:24] = t[31:24] ^ rc;
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_tab[r] = '0;
        for (int r = 0; r < 11; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Advance one cycle and record what the DUT shows in the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < 32) busy_hist[cyc] = bus.busy;
        if (bus.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            done_val = bus.block_out;
        end
    endtask

    // Drive start for the current cycle (cycle 0), then move into cycle 1.
    task automatic issue(input logic [127:0] pt);
        bus.start    = 1'b1;
        bus.block_in = pt;
        cyc          = 0;
        busy_hist    = '0;
        done_cnt     = 0;
        done_cyc     = -1;
        done_val     = '0;
        step();
        bus.start    = 1'b0;
        bus.block_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic test_reset();
        bus.start     = 1'b0;
        bus.block_in  = '0;
        bus.key_ready = 1'b0;
        set_key(KEY_B);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
        checks++; if (bus.block_out !== 128'h0) begin errors++; $display("FAIL reset_block_out: got %h want 0", bus.block_out); end
        checks++; if (bus.round_sel !== 4'd0) begin errors++; $display("FAIL reset_round_sel: got %0d want 0", bus.round_sel); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", bus.busy); end
    endtask

    task automatic test_fips_b();
        set_key(KEY_B);
        bus.key_ready = 1'b1;
        exp_q.push_back(CT_B);
        issue(PT_B);
        for (int k = 1; k <= 10; k++) begin
            checks++;
            if (bus.round_sel !== 4'(k)) begin
                errors++; $display("FAIL b_round_sel c%0d: got %0d want %0d", k, bus.round_sel, k);
            end
            step();
        end
        checks++; if (bus.round_sel !== 4'd0) begin errors++; $display("FAIL b_round_sel_idle: got %0d want 0", bus.round_sel); end
        checks++; if (busy_hist[11:0] !== 12'h7fe) begin errors++; $display("FAIL b_busy_window: got %b want %b", busy_hist[11:0], 12'h7fe); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL b_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL b_done_cycle: got %0d want 11", done_cyc); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (done_val !== exp_v) begin errors++; $display("FAIL b_ciphertext: got %h want %h", done_val, exp_v); end
    endtask

    task automatic test_back_to_back();
        set_key(KEY_C);
        exp_q.push_back(CT_C);
        issue(PT_C);
        repeat (10) step();
        checks++; if (done_cyc !== 11) begin errors++; $display("FAIL c1_done_cycle: got %0d want 11", done_cyc); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (done_val !== exp_v) begin errors++; $display("FAIL c1_ciphertext: got %h want %h", done_val, exp_v); end
        // New request in the done cycle itself.
        exp_q.push_back(CT_C);
        issue(PT_C);
        repeat (10) step();
        checks++; if (busy_hist[11:0] !== 12'h7fe) begin errors++; $display("FAIL c2_busy_window: got %b want %b", busy_hist[11:0], 12'h7fe); end
        checks++; if (done_cnt !== 1 || done_cyc !== 11) begin errors++; $display("FAIL c2_done: got count %0d cycle %0d want 1 at 11", done_cnt, done_cyc); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (done_val !== exp_v) begin errors++; $display("FAIL c2_ciphertext: got %h want %h", done_val, exp_v); end
    endtask

    task automatic test_no_key();
        bus.key_ready = 1'b0;
        bus.start     = 1'b1;
        bus.block_in  = PT_B;
        cyc = 0; busy_hist = '0; done_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            bus.start = (k < 19) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        checks++; if (busy_hist[20:0] !== 21'h0) begin errors++; $display("FAIL nokey_busy: got %b want 0", busy_hist[20:0]); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL nokey_done: got %0d want 0", done_cnt); end
        checks++; if (bus.block_out !== CT_C) begin errors++; $display("FAIL nokey_block_out: got %h want %h", bus.block_out, CT_C); end
        bus.start     = 1'b0;
        bus.key_ready = 1'b1;
    endtask

    task automatic test_start_while_busy();
        int extra;
        extra = $urandom_range(2, 9);
        set_key(KEY_B);
        exp_q.push_back(CT_B);
        issue(PT_B);
        for (int k = 1; k <= 10; k++) begin
            bus.start = (k == 5 || k == extra);
            if (bus.start) bus.block_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            step();
        end
        checks++; if (done_cnt !== 1 || done_cyc !== 11) begin errors++; $display("FAIL busy_start_done: got count %0d cycle %0d want 1 at 11", done_cnt, done_cyc); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (done_val !== exp_v) begin errors++; $display("FAIL busy_start_ciphertext: got %h want %h", done_val, exp_v); end
        repeat (13) step();
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_start_extra_done: got %0d want 1", done_cnt); end
        checks++; if (busy_hist[24:11] !== 14'h0) begin errors++; $display("FAIL busy_start_restart: got %b want 0", busy_hist[24:11]); end
    endtask

    task automatic test_abort();
        issue(PT_C);
        repeat (5) step();
        bus.key_ready = 1'b0;
        step();
        checks++; if (busy_hist[7:1] !== 7'h3f) begin errors++; $display("FAIL abort_busy: got %b want %b", busy_hist[7:1], 7'h3f); end
        repeat (13) step();
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        checks++; if (bus.block_out !== CT_B) begin errors++; $display("FAIL abort_block_out: got %h want %h", bus.block_out, CT_B); end
        bus.key_ready = 1'b1;
    endtask

    task automatic test_reset_mid();
        set_key(KEY_C);
        issue(PT_C);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", bus.done); end
        checks++; if (bus.block_out !== 128'h0) begin errors++; $display("FAIL midrst_block_out: got %h want 0", bus.block_out); end
        checks++; if (bus.round_sel !== 4'd0) begin errors++; $display("FAIL midrst_round_sel: got %0d want 0", bus.round_sel); end
        #2;
        rst_n = 1'b1;
        repeat (12) step();
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
        exp_q.push_back(CT_C);
        issue(PT_C);
        repeat (10) step();
        checks++; if (done_cnt !== 1 || done_cyc !== 11) begin errors++; $display("FAIL midrst_rerun_done: got count %0d cycle %0d want 1 at 11", done_cnt, done_cyc); end
        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++; if (done_val !== exp_v) begin errors++; $display("FAIL midrst_rerun_ciphertext: got %h want %h", done_val, exp_v); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips_b();
        test_back_to_back();
        test_no_key();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
